// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver: one-hot round-robin scan with
// guard blanking, leading-zero suppression and tear-free frame-boundary updates.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 25000,
  parameter int BLANK_CYCLES   = 250,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                    i_CLK,
  input  logic                    i_RST_N,
  input  logic                    i_EN,
  input  logic                    i_LOAD,
  input  logic [4*NUM_DIGITS-1:0] i_VALUE,
  input  logic [NUM_DIGITS-1:0]   i_DP,
  input  logic                    i_LZ_SUPPRESS,
  output logic [6:0]              o_SEG,
  output logic                    o_DP,
  output logic [NUM_DIGITS-1:0]   o_DIG,
  output logic                    o_FRAME
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  // XOR masks: an internal active-high value XOR the mask gives the pin level
  localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                             : {NUM_DIGITS{1'b0}};

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_valid;

  logic                    slot_end;
  logic                    boundary;
  logic                    in_guard;
  logic [3:0]              nibs [NUM_DIGITS];
  logic [3:0]              cur_nib;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    lead;
  logic [6:0]              seg_dec;
  logic [NUM_DIGITS-1:0]   dig_sel;

  assign slot_end = (cnt == CNT_LAST);
  assign boundary = i_EN && slot_end && (idx == IDX_LAST);

  generate
    if (BLANK_CYCLES == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (cnt < CW'(BLANK_CYCLES));
    end
  endgenerate

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      cnt <= '0;
      idx <= '0;
    end else if (!i_EN) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load in the boundary cycle must survive into pending, so it is written last
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      disp_val   <= '0;
      disp_dp    <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (boundary && pend_valid) begin
        disp_val   <= pend_val;
        disp_dp    <= pend_dp;
        pend_valid <= 1'b0;
      end
      if (i_LOAD) begin
        pend_val   <= i_VALUE;
        pend_dp    <= i_DP;
        pend_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    lead     = 1'b1;
    lz_blank = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nibs[k] = disp_val[4*k +: 4];
    end
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lead = lead & (disp_val[4*k +: 4] == 4'h0);
      if (k != 0) begin
        lz_blank[k] = i_LZ_SUPPRESS & lead;
      end
    end
  end

  assign cur_nib = nibs[idx];
  assign dig_sel = NUM_DIGITS'(1) << idx;

  always_comb begin
    seg_dec = 7'h00;
    case (cur_nib)
      4'h0: seg_dec = 7'h3F;
      4'h1: seg_dec = 7'h06;
      4'h2: seg_dec = 7'h5B;
      4'h3: seg_dec = 7'h4F;
      4'h4: seg_dec = 7'h66;
      4'h5: seg_dec = 7'h6D;
      4'h6: seg_dec = 7'h7D;
      4'h7: seg_dec = 7'h07;
      4'h8: seg_dec = 7'h7F;
      4'h9: seg_dec = 7'h67;
      4'hA: seg_dec = 7'h77;
      4'hB: seg_dec = 7'h7C;
      4'hC: seg_dec = 7'h39;
      4'hD: seg_dec = 7'h5E;
      4'hE: seg_dec = 7'h79;
      4'hF: seg_dec = 7'h71;
      default: seg_dec = 7'h00;
    endcase
  end

  // Outputs are a registered image of the pre-edge counter/index/display state
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      o_SEG   <= SEG_OFF;
      o_DP    <= DP_OFF;
      o_DIG   <= DIG_OFF;
      o_FRAME <= 1'b0;
    end else begin
      o_FRAME <= boundary;
      if (!i_EN || in_guard) begin
        o_SEG <= SEG_OFF;
        o_DP  <= DP_OFF;
        o_DIG <= DIG_OFF;
      end else begin
        o_SEG <= (lz_blank[idx] ? 7'h00 : seg_dec) ^ SEG_OFF;
        o_DP  <= disp_dp[idx] ^ DP_OFF;
        o_DIG <= dig_sel ^ DIG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: two instances (active-high and
// active-low pins) share stimulus and are checked cycle by cycle over whole frames.
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        lz = 1'b0;

  logic [6:0]  seg_hi, seg_lo;
  logic        dp_hi, dp_lo;
  logic [3:0]  dig_hi, dig_lo;
  logic        frame_hi, frame_lo;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][6:0] segs;
  } vec_t;

  vec_t       vecs [24];
  logic [6:0] dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut_hi (
    .i_CLK(clk), .i_RST_N(rst_n), .i_EN(en), .i_LOAD(load),
    .i_VALUE(value), .i_DP(dp), .i_LZ_SUPPRESS(lz),
    .o_SEG(seg_hi), .o_DP(dp_hi), .o_DIG(dig_hi), .o_FRAME(frame_hi)
  );

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut_lo (
    .i_CLK(clk), .i_RST_N(rst_n), .i_EN(en), .i_LOAD(load),
    .i_VALUE(value), .i_DP(dp), .i_LZ_SUPPRESS(lz),
    .o_SEG(seg_lo), .o_DP(dp_lo), .o_DIG(dig_lo), .o_FRAME(frame_lo)
  );

  task automatic check_output(input string name, input int cyc,
                              input logic [12:0] act, input logic [12:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s cyc %0d: got {dig,seg,dp,frame}=%h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_idle(input string name, input int cyc);
    check_output(name, cyc, {dig_hi, seg_hi, dp_hi, frame_hi}, 13'h0000);
    check_output({name, "/lo"}, cyc, {dig_lo, seg_lo, dp_lo, frame_lo},
                 {4'hF, 7'h7F, 1'b1, 1'b0});
  endtask

  task automatic apply_stimulus(input logic [15:0] v, input logic [3:0] d, input logic z);
    value = v;
    dp    = d;
    lz    = z;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    logic got;
    int   waited;
    got    = 1'b0;
    waited = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      waited = i;
      if (frame_hi === 1'b1) got = 1'b1;
    end
    check_output({name, "/frame_wait"}, waited, {12'h000, got}, 13'h0001);
  endtask

  // Starts at the negedge that sees o_FRAME: slot s = k-1 covers digit s/8, with
  // positions 0..1 of each slot blank and the next o_FRAME at k == 32
  task automatic check_frame(input string name, input logic [3:0][6:0] segs,
                             input logic [3:0] dps);
    int         s;
    int         d;
    logic       guard;
    logic [3:0] e_dig;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fr;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      s     = k - 1;
      d     = s / 8;
      guard = (s % 8) < 2;
      e_dig = guard ? 4'b0000 : (4'b0001 << d);
      e_seg = guard ? 7'h00 : segs[d];
      e_dp  = guard ? 1'b0 : dps[d];
      e_fr  = (k == 32);
      check_output(name, k, {dig_hi, seg_hi, dp_hi, frame_hi}, {e_dig, e_seg, e_dp, e_fr});
      check_output({name, "/lo"}, k, {dig_lo, seg_lo, dp_lo, frame_lo},
                   {~e_dig, ~e_seg, ~e_dp, e_fr});
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{value:16'h1234, dp:4'b0000, lz:1'b0, segs:{7'h06, 7'h5B, 7'h4F, 7'h66}};
    vecs[1] = '{value:16'h0050, dp:4'b0000, lz:1'b1, segs:{7'h00, 7'h00, 7'h6D, 7'h3F}};
    vecs[2] = '{value:16'h0000, dp:4'b1000, lz:1'b1, segs:{7'h00, 7'h00, 7'h00, 7'h3F}};
    vecs[3] = '{value:16'h0F00, dp:4'b0000, lz:1'b1, segs:{7'h00, 7'h71, 7'h3F, 7'h3F}};
    vecs[4] = '{value:16'hABCD, dp:4'b0101, lz:1'b1, segs:{7'h77, 7'h7C, 7'h39, 7'h5E}};
    vecs[5] = '{value:16'h0008, dp:4'b0001, lz:1'b1, segs:{7'h00, 7'h00, 7'h00, 7'h7F}};
    vecs[6] = '{value:16'h6789, dp:4'b1010, lz:1'b0, segs:{7'h7D, 7'h07, 7'h7F, 7'h67}};
    vecs[7] = '{value:16'h0E0B, dp:4'b0000, lz:1'b1, segs:{7'h00, 7'h79, 7'h3F, 7'h7C}};
    for (int n = 0; n < 16; n++) begin
      vecs[8 + n] = '{value:{12'h000, 4'(n)}, dp:4'b0000, lz:1'b0,
                      segs:{7'h3F, 7'h3F, 7'h3F, dec[n]}};
    end

    $display("[TB] reset");
    #1 rst_n = 1'b0;
    #2 check_idle("reset_async", 0);
    repeat (3) @(negedge clk);
    check_idle("reset_hold", 0);
    en    = 1'b1;
    rst_n = 1'b1;
    check_frame("boot_zero", {4{7'h3F}}, 4'b0000);

    $display("[TB] vector table");
    for (int i = 0; i < 24; i++) begin
      apply_stimulus(vecs[i].value, vecs[i].dp, vecs[i].lz);
      wait_frame($sformatf("vec%0d", i));
      check_frame($sformatf("vec%0d_%h", i, vecs[i].value), vecs[i].segs, vecs[i].dp);
    end

    $display("[TB] mid-frame double load");
    fork
      check_frame("tear_old", {7'h3F, 7'h3F, 7'h3F, 7'h71}, 4'b0000);
      begin
        repeat (10) @(negedge clk);
        value = 16'h1111;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        @(negedge clk);
        value = 16'h2222;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
      end
    join
    check_frame("tear_new", {4{7'h5B}}, 4'b0000);

    $display("[TB] enable drop and reset mid-scan");
    repeat (12) @(negedge clk);
    en    = 1'b0;
    value = 16'hC0DE;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check_idle("en_off", 1);
    for (int i = 2; i < 22; i++) begin
      @(negedge clk);
      check_idle("en_off_hold", i);
    end
    en = 1'b1;
    check_frame("reen_old", {4{7'h5B}}, 4'b0000);
    check_frame("reen_new", {7'h39, 7'h3F, 7'h5E, 7'h79}, 4'b0000);

    apply_stimulus(16'h9999, 4'b1111, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle("rst_mid_async", 0);
    @(negedge clk);
    check_idle("rst_mid_hold", 1);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame("post_rst", {4{7'h3F}}, 4'b0000);
    check_frame("post_rst_pend_lost", {4{7'h3F}}, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Parametrised multi-digit, time-multiplexed 7-segment display driver. Successor to the single-digit binary-to-7-segment decoder. Holds a packed hex value and scans digits round-robin, one-hot. Adds several features:
- decode of 0-F per digit
- decimal points
- leading-zero suppression
- anti-ghosting guard interval
- tear-free frame-boundary update
- selectable output polarity

Sits between game-state logic and the board's 7-segment pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
SCAN_DIV, 25000, clock cycles per digit slot (1 ms at 25 MHz); must be > BLANK_CYCLES
BLANK_CYCLES, 250, cycles at the start of each slot with all digits off (guard); 0 allowed
SEG_ACTIVE_LOW, 0, 1 = segment and DP outputs driven low when lit
DIG_ACTIVE_LOW, 0, 1 = digit enables driven low when selected

Ports:
i_CLK  in  1  system clock (25 MHz)
i_RST_N  in  1  asynchronous active-low reset
i_EN  in  1  scan enable; 0 = display dark
i_LOAD  in  1  capture i_VALUE/i_DP into the pending register
i_VALUE  in  4*NUM_DIGITS  hex nibbles; nibble k = digit k, digit 0 least significant
i_DP  in  NUM_DIGITS  decimal point per digit
i_LZ_SUPPRESS  in  1  blank leading zero digits
o_SEG  out  7  o_SEG[0]=a ... o_SEG[6]=g
o_DP  out  1  decimal point of active digit
o_DIG  out  NUM_DIGITS  one-hot digit enable
o_FRAME  out  1  one-cycle pulse at each frame start

Behaviour:
- **Reset (i_RST_N=0, async):**
  - o_SEG, o_DP and o_DIG are at their inactive level, with polarity applied.
  - o_FRAME=0.
  - Digit index=0, slot counter=0.
  - Display and pending registers=0; pending_valid=0.
  - Release is synchronous to i_CLK.
- **All outputs are registered.** Outputs at cycle t reflect the counter, index and display state at t-1.
- **Slot counter** runs 0..SCAN_DIV-1.
  - On wrap, the index advances 0→1→…→NUM_DIGITS-1→0.
  - While the counter is < BLANK_CYCLES, o_DIG is all inactive and o_SEG/o_DP are inactive (GUARD).
  - Otherwise o_DIG selects the index digit (SHOW).
- **Frame boundary** is the transition (index NUM_DIGITS-1, cnt SCAN_DIV-1) → (0, 0).
  - At that edge, if pending_valid: display ← pending, and pending_valid ← 0.
  - o_FRAME pulses high for one cycle, on the output cycle following the boundary edge.
- **i_LOAD:** the pending register is overwritten and pending_valid set on every clock with i_LOAD=1.
  - The latest load before a boundary wins.
  - A load on the boundary cycle itself goes to pending and is applied at the next boundary.
- **Decode per digit** (segments lit, a..g):
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg
  - 4=bcfg, 5=acdfg, 6=acdefg, 7=abc
  - 8=abcdefg, 9=abcfg, A=abcefg, b=cdefg
  - C=adef, d=bcdeg, E=adefg, F=aefg
- **Leading-zero suppression** (i_LZ_SUPPRESS=1):
  - Scanning from digit NUM_DIGITS-1 downward, digits whose nibble is 0 are blanked (segments inactive) until the first nonzero nibble.
  - Digit 0 is never suppressed.
  - A suppressed digit's o_DIG is still asserted, and its DP is still shown.
  - i_LZ_SUPPRESS is sampled live, not via pending.
- **o_DP** = the display DP bit of the active digit, inactive in GUARD.
- **Polarity:** SEG_ACTIVE_LOW inverts o_SEG and o_DP; DIG_ACTIVE_LOW inverts o_DIG. Internal logic is active-high.
- **i_EN=0:**
  - Counter and index are forced to 0 and outputs go inactive on the next edge.
  - o_FRAME stays 0.
  - Pending and display registers are unaffected; loads are still accepted.
- **i_EN 0→1:** scanning restarts at digit 0 with a GUARD slot. The first boundary occurs after a full frame.
- **Reset mid-scan:** immediate inactive outputs; pending load is lost.
- **Invariant:** o_DIG is never more than one-hot.

Test Plan:
Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, both polarity parameters 0 unless stated.
1. Reset, then i_EN=1, load 16'h1234 with i_DP=0 → after the first boundary:
   - digit slots show o_DIG=0001/0010/0100/1000 with o_SEG=7'h4F(3... per slot order 4,3,2,1 → 0x66,0x4F,0x5B,0x06 for digits 0..3);
   - each slot has 2 cycles of o_DIG=0 then 6 cycles lit;
   - o_FRAME pulses every 32 cycles.
2. Sweep each nibble 0-F in digit 0 → o_SEG matches the decode table for all 16 values (e.g. A=7'h77, F=7'h71).
3. Load 16'h0050 with i_LZ_SUPPRESS=1 → digits 3 and 2 have segments 0 while still selected; digit 1 shows 5 (7'h6D); digit 0 shows 0 (7'h3F).
4. Load 16'h1111 mid-frame, then 16'h2222 two cycles later → the display does not change until the boundary, then shows only 2222; no mixed frame is ever seen.
5. SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1, value 8 with DP=1 on digit 0 → o_SEG=7'h00, o_DP=0, o_DIG=4'b1110 in the digit 0 lit window; all ones in GUARD.
6. Deassert i_EN mid-slot, then pulse i_RST_N low mid-slot:
   - outputs go inactive within 1 cycle (and immediately on reset);
   - o_FRAME=0;
   - on re-enable, scanning restarts at digit 0 with a guard slot.
